// File: rtl/io_uart_bridge.sv
// UART peripheral on the processor's 8-bit I/O port: received frames pulse fgi_in,
// OUT strobes are serialised onto tx and pulse fgo_in when the stop bit ends.
module io_uart_bridge #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned IO_WIDTH     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx,
   output logic                tx,
   output logic [IO_WIDTH-1:0] inpr_data,
   output logic                fgi_in,
   input  logic                in_ack,
   input  logic [IO_WIDTH-1:0] outr_data,
   input  logic                out_load,
   output logic                fgo_in,
   output logic                tx_busy,
   output logic                rx_full,
   output logic                rx_overrun,
   output logic                frame_err,
   input  logic                err_clr
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(IO_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(IO_WIDTH - 1);

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_START = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;
   localparam logic [1:0] R_STOP  = 2'd3;

   localparam logic [1:0] T_IDLE  = 2'd0;
   localparam logic [1:0] T_START = 2'd1;
   localparam logic [1:0] T_DATA  = 2'd2;
   localparam logic [1:0] T_STOP  = 2'd3;

   // rx synchroniser and edge history
   logic rx_meta_q, rx_s_q, rx_prev_q;
   logic rx_fall_c;

   // post-reset arming: rx must be idle-high for a full bit time
   logic              armed_q, armed_d;
   logic [BAUD_W-1:0] arm_cnt_q, arm_cnt_d;

   logic [1:0]          r_state_q, r_state_d;
   logic [BAUD_W-1:0]   r_baud_q, r_baud_d;
   logic [BIT_W-1:0]    r_bit_q, r_bit_d;
   logic [IO_WIDTH-1:0] r_shift_q, r_shift_d;
   logic [IO_WIDTH-1:0] inpr_q, inpr_d;
   logic                fgi_q, fgi_d;
   logic                rx_full_q, rx_full_d;
   logic                ovr_q, ovr_d;
   logic                ferr_q, ferr_d;

   logic [1:0]          t_state_q, t_state_d;
   logic [BAUD_W-1:0]   t_baud_q, t_baud_d;
   logic [BIT_W-1:0]    t_bit_q, t_bit_d;
   logic [IO_WIDTH-1:0] t_shift_q, t_shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                fgo_q, fgo_d;

   assign rx_fall_c = rx_prev_q & ~rx_s_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         armed_q   <= 1'b0;
         arm_cnt_q <= '0;
         r_state_q <= R_IDLE;
         r_baud_q  <= '0;
         r_bit_q   <= '0;
         r_shift_q <= '0;
         inpr_q    <= '0;
         fgi_q     <= 1'b0;
         rx_full_q <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
         t_state_q <= T_IDLE;
         t_baud_q  <= '0;
         t_bit_q   <= '0;
         t_shift_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         fgo_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         armed_q   <= armed_d;
         arm_cnt_q <= arm_cnt_d;
         r_state_q <= r_state_d;
         r_baud_q  <= r_baud_d;
         r_bit_q   <= r_bit_d;
         r_shift_q <= r_shift_d;
         inpr_q    <= inpr_d;
         fgi_q     <= fgi_d;
         rx_full_q <= rx_full_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
         t_state_q <= t_state_d;
         t_baud_q  <= t_baud_d;
         t_bit_q   <= t_bit_d;
         t_shift_q <= t_shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         fgo_q     <= fgo_d;
      end
   end

   // arming counter; once armed it stays armed until the next reset
   always_comb begin
      armed_d   = armed_q;
      arm_cnt_d = arm_cnt_q;
      if (!armed_q) begin
         if (!rx_s_q) begin
            arm_cnt_d = '0;
         end else if (arm_cnt_q == BAUD_LAST) begin
            armed_d   = 1'b1;
            arm_cnt_d = '0;
         end else begin
            arm_cnt_d = arm_cnt_q + BAUD_W'(1);
         end
      end
   end

   // receive FSM; a completing frame overrides a same-cycle ack or error clear
   always_comb begin
      r_state_d = r_state_q;
      r_baud_d  = r_baud_q;
      r_bit_d   = r_bit_q;
      r_shift_d = r_shift_q;
      inpr_d    = inpr_q;
      fgi_d     = 1'b0;
      rx_full_d = rx_full_q;
      ovr_d     = ovr_q;
      ferr_d    = ferr_q;

      if (in_ack) rx_full_d = 1'b0;
      if (err_clr) begin
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end

      case (r_state_q)
         R_IDLE: begin
            if (armed_q && rx_fall_c) begin
               r_state_d = R_START;
               r_baud_d  = '0;
               r_bit_d   = '0;
            end
         end
         R_START: begin
            if (r_baud_q == BAUD_HALF) begin
               r_baud_d  = '0;
               r_state_d = rx_s_q ? R_IDLE : R_DATA;
            end else begin
               r_baud_d = r_baud_q + BAUD_W'(1);
            end
         end
         R_DATA: begin
            if (r_baud_q == BAUD_LAST) begin
               r_baud_d  = '0;
               r_shift_d = {rx_s_q, r_shift_q[IO_WIDTH-1:1]};
               if (r_bit_q == BIT_LAST) begin
                  r_state_d = R_STOP;
               end else begin
                  r_bit_d = r_bit_q + BIT_W'(1);
               end
            end else begin
               r_baud_d = r_baud_q + BAUD_W'(1);
            end
         end
         R_STOP: begin
            if (r_baud_q == BAUD_LAST) begin
               r_baud_d  = '0;
               r_state_d = R_IDLE;
               if (rx_s_q) begin
                  inpr_d    = r_shift_q;
                  fgi_d     = 1'b1;
                  rx_full_d = 1'b1;
                  if (rx_full_q && !in_ack) ovr_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               r_baud_d = r_baud_q + BAUD_W'(1);
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // transmit FSM; tx is updated one step ahead so it changes on bit boundaries
   always_comb begin
      t_state_d = t_state_q;
      t_baud_d  = t_baud_q;
      t_bit_d   = t_bit_q;
      t_shift_d = t_shift_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      fgo_d     = 1'b0;

      case (t_state_q)
         T_IDLE: begin
            tx_d = 1'b1;
            if (out_load) begin
               t_shift_d = outr_data;
               busy_d    = 1'b1;
               tx_d      = 1'b0;
               t_baud_d  = '0;
               t_bit_d   = '0;
               t_state_d = T_START;
            end
         end
         T_START: begin
            if (t_baud_q == BAUD_LAST) begin
               t_baud_d  = '0;
               tx_d      = t_shift_q[0];
               t_shift_d = t_shift_q >> 1;
               t_state_d = T_DATA;
            end else begin
               t_baud_d = t_baud_q + BAUD_W'(1);
            end
         end
         T_DATA: begin
            if (t_baud_q == BAUD_LAST) begin
               t_baud_d = '0;
               if (t_bit_q == BIT_LAST) begin
                  tx_d      = 1'b1;
                  t_state_d = T_STOP;
               end else begin
                  tx_d      = t_shift_q[0];
                  t_shift_d = t_shift_q >> 1;
                  t_bit_d   = t_bit_q + BIT_W'(1);
               end
            end else begin
               t_baud_d = t_baud_q + BAUD_W'(1);
            end
         end
         T_STOP: begin
            if (t_baud_q == BAUD_LAST) begin
               t_baud_d  = '0;
               fgo_d     = 1'b1;
               busy_d    = 1'b0;
               t_state_d = T_IDLE;
            end else begin
               t_baud_d = t_baud_q + BAUD_W'(1);
            end
         end
         default: t_state_d = T_IDLE;
      endcase
   end

   assign tx         = tx_q;
   assign inpr_data  = inpr_q;
   assign fgi_in     = fgi_q;
   assign fgo_in     = fgo_q;
   assign tx_busy    = busy_q;
   assign rx_full    = rx_full_q;
   assign rx_overrun = ovr_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_io_uart_bridge.sv
// Randomised bench for io_uart_bridge with a frame-level reference model of the RX flags and TX waveform.
module tb_io_uart_bridge;

   localparam int unsigned CPB = 16;
   localparam int unsigned W   = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         rx;
   logic         tx;
   logic [W-1:0] inpr_data;
   logic         fgi_in;
   logic         in_ack;
   logic [W-1:0] outr_data;
   logic         out_load;
   logic         fgo_in;
   logic         tx_busy;
   logic         rx_full;
   logic         rx_overrun;
   logic         frame_err;
   logic         err_clr;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [W-1:0] m_data;
   logic         m_full, m_ovr, m_ferr;
   int           m_fgi;

   int fgi_cycles = 0;
   int fgo_cycles = 0;

   io_uart_bridge #(.CLKS_PER_BIT(CPB), .IO_WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .tx         (tx),
      .inpr_data  (inpr_data),
      .fgi_in     (fgi_in),
      .in_ack     (in_ack),
      .outr_data  (outr_data),
      .out_load   (out_load),
      .fgo_in     (fgo_in),
      .tx_busy    (tx_busy),
      .rx_full    (rx_full),
      .rx_overrun (rx_overrun),
      .frame_err  (frame_err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fgi_in) fgi_cycles++;
      if (fgo_in) fgo_cycles++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_data = '0;
      m_full = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic check_rx(input string tag);
      check_val({tag, ".data"},    32'(inpr_data),  32'(m_data));
      check_val({tag, ".full"},    32'(rx_full),    32'(m_full));
      check_val({tag, ".overrun"}, 32'(rx_overrun), 32'(m_ovr));
      check_val({tag, ".ferr"},    32'(frame_err),  32'(m_ferr));
      check_val({tag, ".fgi"},     32'(fgi_cycles), 32'(m_fgi));
   endtask

   // drive one UART frame on rx and advance the model
   task automatic send_frame(input logic [W-1:0] b, input logic stop_ok);
      logic [W+1:0] bits;
      bits = {stop_ok, b, 1'b0};
      for (int i = 0; i < W + 2; i++) begin
         rx = bits[i];
         idle(CPB);
      end
      rx = 1'b1;
      idle(CPB);
      if (stop_ok) begin
         if (m_full) m_ovr = 1'b1;
         m_data = b;
         m_full = 1'b1;
         m_fgi++;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   task automatic pulse_ack();
      in_ack = 1'b1;
      idle(1);
      in_ack = 1'b0;
      m_full = 1'b0;
      idle(1);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      idle(1);
   endtask

   // load a byte, then watch the whole frame; optionally fire an ignored load at cycle 50
   task automatic tx_frame(input logic [W-1:0] b, input logic extra_load);
      int          match;
      int          fgo_base;
      logic [W+1:0] bits;
      bits = {1'b1, b, 1'b0};
      outr_data = b;
      out_load  = 1'b1;
      fgo_base  = fgo_cycles;
      for (int bi = 0; bi < W + 2; bi++) begin
         match = 0;
         for (int s = 0; s < CPB; s++) begin
            idle(1);
            if (bi == 0 && s == 0) begin
               out_load = 1'b0;
               check_val("tx.busy_start", 32'(tx_busy), 32'd1);
            end
            if (extra_load && bi * CPB + s == 50) begin
               out_load  = 1'b1;
               outr_data = W'($urandom);
            end else if (extra_load && bi * CPB + s == 51) begin
               out_load = 1'b0;
            end
            if (tx === bits[bi]) match++;
         end
         check_val($sformatf("tx.bit%0d", bi), 32'(match), 32'(CPB));
      end
      check_val("tx.no_early_fgo", 32'(fgo_cycles - fgo_base), 32'd0);
      check_val("tx.busy_last", 32'(tx_busy), 32'd1);
      idle(1);
      check_val("tx.fgo_at_160", 32'(fgo_in), 32'd1);
      check_val("tx.busy_drop", 32'(tx_busy), 32'd0);
      idle(1);
      check_val("tx.fgo_single", 32'(fgo_cycles - fgo_base), 32'd1);
      check_val("tx.idle_line", 32'(tx), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      rx        = 1'b1;
      in_ack    = 1'b0;
      err_clr   = 1'b0;
      out_load  = 1'b0;
      outr_data = '0;
      model_reset();
      m_fgi = 0;
      idle(3);
      check_val("rst.tx",   32'(tx),      32'd1);
      check_val("rst.fgo",  32'(fgo_in),  32'd0);
      check_val("rst.busy", 32'(tx_busy), 32'd0);
      check_rx("rst");
      reset = 1'b0;
      idle(2 * CPB);

      // directed frames
      send_frame(8'hA5, 1'b1);
      check_rx("rx_a5");
      pulse_ack();
      check_rx("rx_a5_ack");

      tx_frame(8'h3C, 1'b1);

      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check_rx("rx_overrun");
      pulse_clr();
      check_rx("rx_errclr");
      pulse_ack();

      send_frame(8'h5A, 1'b0);
      idle(CPB);
      check_rx("rx_ferr");
      pulse_clr();

      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(3 * CPB);
      check_rx("rx_glitch");
      send_frame(8'hC3, 1'b1);
      check_rx("rx_after_glitch");
      pulse_ack();

      // randomised RX traffic
      for (int n = 0; n < 8; n++) begin
         logic [W-1:0] b;
         logic         ok;
         b  = W'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send_frame(b, ok);
         if (!ok) idle(CPB);
         check_rx($sformatf("rx_rand%0d", n));
         if ($urandom_range(0, 1) == 1) pulse_ack();
         if ($urandom_range(0, 2) == 0) pulse_clr();
      end

      // randomised back-to-back TX
      for (int n = 0; n < 3; n++) tx_frame(W'($urandom), 1'b0);

      // reset in the middle of a transmit frame
      outr_data = W'($urandom);
      out_load  = 1'b1;
      idle(1);
      out_load = 1'b0;
      idle(60);
      reset = 1'b1;
      #1;
      check_val("midrst.tx",   32'(tx),      32'd1);
      check_val("midrst.busy", 32'(tx_busy), 32'd0);
      model_reset();
      check_rx("midrst");
      idle(2);
      reset = 1'b0;
      begin
         int fgo_base;
         fgo_base = fgo_cycles;
         idle(200);
         check_val("midrst.no_fgo", 32'(fgo_cycles - fgo_base), 32'd0);
      end
      tx_frame(8'h7E, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_uart_bridge.md
Name: io_uart_bridge

Overview:
- Serial peripheral adapter that sits directly on the processor's 8-bit I/O port.
- Receives UART frames and presents each byte on inpr_data, with a one-cycle fgi_in pulse that sets the processor's input flag.
- Serialises the byte captured from outr_data when the OUT strobe fires, and pulses fgo_in once the frame has left the line, which clears the processor's output flag.
- Replaces the testbench-driven I/O flags with real sequential peripheral behaviour.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is >= 4, and must be even.
- IO_WIDTH, 8, data bits per frame; matches the processor I/O width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- tx  out  1  serial output, idle high.
- inpr_data  out  IO_WIDTH  last received byte; connects to processor inpr_data.
- fgi_in  out  1  one-cycle pulse when a new byte is valid; connects to processor fgi_in.
- in_ack  in  1  INP strobe from the processor; consumes the held byte.
- outr_data  in  IO_WIDTH  processor output register.
- out_load  in  1  OUT strobe from the processor; samples outr_data on the following cycle.
- fgo_in  out  1  one-cycle pulse when transmission completes; connects to processor fgo_in.
- tx_busy  out  1  high from the accepted load until the end of the stop bit.
- rx_full  out  1  byte held and not yet acked.
- rx_overrun  out  1  sticky; a byte arrived while rx_full was set.
- frame_err  out  1  sticky; a stop bit was sampled low.
- err_clr  in  1  clears rx_overrun and frame_err.

Behaviour:
- Reset values: tx=1, inpr_data=0, fgi_in=0, fgo_in=0, tx_busy=0, rx_full=0, rx_overrun=0, frame_err=0. All FSMs go to IDLE and all counters to 0.
- Reset applies immediately, even mid-frame. After release, any partial frame on rx is discarded until rx has been seen high for 1 bit time.
- rx passes through a 2-flop synchroniser (rx_s) before any use, adding 2 cycles of input latency.

RX FSM (R_IDLE, R_START, R_DATA, R_STOP):
- R_IDLE: a falling edge on rx_s moves to R_START and loads the bit counter.
- R_START: re-samples at CLKS_PER_BIT/2. If rx_s=0, go to R_DATA; if 1, it was a glitch, return to R_IDLE with no flags touched.
- R_DATA: samples every CLKS_PER_BIT, LSB first, IO_WIDTH bits into a shift register.
- R_STOP: samples once.
  - Stop bit = 1: inpr_data <= shift register, fgi_in pulses high for exactly 1 cycle on the same edge, rx_full <= 1. If rx_full was already 1, rx_overrun <= 1 and the new byte overwrites the old one.
  - Stop bit = 0: frame_err <= 1. inpr_data, rx_full and fgi_in are unchanged.
  - Either way, return to R_IDLE.
- in_ack clears rx_full. If in_ack and a byte-complete event occur on the same cycle, the completion wins: rx_full stays 1 and no overrun is flagged.
- err_clr clears both sticky flags. If err_clr and a new error occur on the same cycle, the new error wins.

TX FSM (T_IDLE, T_START, T_DATA, T_STOP):
- out_load is accepted only in T_IDLE. Accepting it latches outr_data into the shift register, sets tx_busy, and moves to T_START.
- out_load while tx_busy=1 is ignored; the byte is not queued.
- T_START: tx=0 for CLKS_PER_BIT cycles.
- T_DATA: IO_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles.
- T_STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, fgo_in pulses for 1 cycle, tx_busy drops and the FSM returns to T_IDLE.
- Timing: the start bit begins the cycle after out_load. Total frame = (IO_WIDTH+2)*CLKS_PER_BIT cycles.
- A new out_load is accepted on the cycle tx_busy is low, so frames can run back to back with no idle gap beyond that 1 cycle.
- tx is registered, so it never glitches.

Counters:
- Baud counters are $clog2(CLKS_PER_BIT) bits wide and wrap to 0 on reaching CLKS_PER_BIT-1.
- Bit counters are $clog2(IO_WIDTH+1) bits wide.

Test Plan:
- Send 0xA5 on rx at CLKS_PER_BIT=16. Required: inpr_data=0xA5, one fgi_in pulse, rx_full=1, frame_err=0. Then in_ack → rx_full=0.
- Pulse out_load with outr_data=0x3C. Required: tx shows start 0, bits 0,0,1,1,1,1,0,0, stop 1, each 16 cycles long. fgo_in pulses exactly 160 cycles after the start bit begins. A second out_load at cycle 50 is ignored.
- Send two frames 0x11 then 0x22 with no in_ack. Required: inpr_data=0x22, rx_overrun=1, two fgi_in pulses. err_clr → rx_overrun=0.
- Send a frame with stop bit 0. Required: frame_err=1, no fgi_in pulse, inpr_data unchanged.
- Drive an rx low glitch of 4 cycles. Required: no state change and no flags set.
- Assert reset in the middle of a TX frame. Required: tx=1 immediately, tx_busy=0, no fgo_in pulse. A subsequent out_load with 0x7E transmits correctly.
